mac_accumulator: RTL



---
 rtl/mac_accumulator_pkg.sv | 55 +++++
 rtl/mac_accumulator_adder.sv | 37 +++
 rtl/mac_accumulator.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mac_accumulator_pkg.sv
// rtl/mac_accumulator_pkg.sv - shared MAC constants, state enum and saturation helper
package mac_accumulator_pkg;

  localparam int ACC_W  = 48;
  localparam int LANE_W = 24;

  localparam logic [LANE_W-1:0] LANE_MAX = 24'h7F_FFFF;
  localparam logic [LANE_W-1:0] LANE_MIN = 24'h80_0000;
  localparam logic [ACC_W-1:0]  FULL_MAX = 48'h7FFF_FFFF_FFFF;
  localparam logic [ACC_W-1:0]  FULL_MIN = 48'h8000_0000_0000;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  // Saturated sum plus per-lane overflow flags ([0] low/full, [1] high lane).
  typedef struct packed {
    logic [ACC_W-1:0] value;
    logic [1:0]       flags;
  } sat_t;

  // Overflow is judged from operand and sum sign bits only: equal operand
  // signs with a differing sum sign. The adder's own overflow is not used.
  function automatic sat_t sat48(input logic [ACC_W-1:0] a,
                                 input logic [ACC_W-1:0] b,
                                 input logic [ACC_W-1:0] sum,
                                 input logic             split);
    sat_t r;
    logic ov_lo;
    logic ov_hi;
    logic ov_full;
    r.value = sum;
    r.flags = 2'b00;
    ov_lo   = (a[LANE_W-1] == b[LANE_W-1]) && (sum[LANE_W-1] != a[LANE_W-1]);
    ov_hi   = (a[ACC_W-1] == b[ACC_W-1]) && (sum[ACC_W-1] != a[ACC_W-1]);
    ov_full = ov_hi;
    if (split) begin
      if (ov_lo) begin
        r.value[LANE_W-1:0] = a[LANE_W-1] ? LANE_MIN : LANE_MAX;
      end
      if (ov_hi) begin
        r.value[ACC_W-1:LANE_W] = a[ACC_W-1] ? LANE_MIN : LANE_MAX;
      end
      r.flags = {ov_hi, ov_lo};
    end else begin
      if (ov_full) begin
        r.value = a[ACC_W-1] ? FULL_MIN : FULL_MAX;
      end
      r.flags = {1'b0, ov_full};
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_accumulator_adder.sv
// rtl/mac_accumulator_adder.sv - 48-bit adder with optional carry split at the lane boundary
module adder #(
  parameter int W = 48
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  input  logic         split_i,
  output logic [W-1:0] sum_o,
  output logic         overflow_o
);

  localparam int H = W / 2;

  logic [H:0]   lo_sum;
  logic         mid_carry;
  logic [H-1:0] hi_sum;
  logic         ov_lo;
  logic         ov_hi;

  // Low lane keeps its carry-out so full mode can chain it into the high lane.
  always_comb begin
    lo_sum    = {1'b0, a_i[H-1:0]} + {1'b0, b_i[H-1:0]} + {{H{1'b0}}, cin_i};
    mid_carry = split_i ? 1'b0 : lo_sum[H];
    hi_sum    = a_i[W-1:H] + b_i[W-1:H] + {{(H-1){1'b0}}, mid_carry};
  end

  assign sum_o = {hi_sum, lo_sum[H-1:0]};

  // Signed overflow per lane; in full mode only the top sign matters.
  always_comb begin
    ov_lo      = (a_i[H-1] == b_i[H-1]) && (lo_sum[H-1] != a_i[H-1]);
    ov_hi      = (a_i[W-1] == b_i[W-1]) && (hi_sum[H-1] != a_i[W-1]);
    overflow_o = split_i ? (ov_lo | ov_hi) : ov_hi;
  end

endmodule

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - saturating window accumulator with result handshake
module mac_accumulator
  import mac_accumulator_pkg::*;
#(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_prod,
  input  logic         in_first,
  input  logic         in_last,
  input  logic         in_split,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_sat,
  output logic         err
);

  state_e       state_q,     state_d;
  logic [W-1:0] acc_q,       acc_d;
  logic         split_q,     split_d;
  logic [1:0]   wflags_q,    wflags_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q,  out_data_d;
  logic [1:0]   out_sat_q,   out_sat_d;
  logic         err_q,       err_d;

  logic         beat_fire;
  logic         win_start;
  logic         mode;
  logic [W-1:0] b_operand;
  logic [W-1:0] sum;
  logic [1:0]   flags_new;
  logic         proto_err;
  sat_t         sat_res;

  // The output register must be free (or draining this cycle) to take a beat.
  assign in_ready  = !rst && (!out_valid_q || out_ready);
  assign beat_fire = in_valid && in_ready;

  // A window opens on in_first or on any beat arriving with no window open.
  always_comb begin
    win_start = in_first || (state_q == IDLE);
    mode      = win_start ? in_split : split_q;
    b_operand = win_start ? '0 : acc_q;
  end

  adder #(
    .W(W)
  ) u_adder (
    .a_i       (in_prod),
    .b_i       (b_operand),
    .cin_i     (1'b0),
    .split_i   (mode),
    .sum_o     (sum),
    .overflow_o()
  );

  // Saturate the raw sum and merge the lane flags into the window's history.
  always_comb begin
    sat_res   = sat48(in_prod, b_operand, sum, mode);
    flags_new = (win_start ? 2'b00 : wflags_q) | sat_res.flags;
  end

  // Restart inside a window, orphan continuation beat, or a lane-mode change mid-window.
  always_comb begin
    proto_err = 1'b0;
    if (in_first && (state_q == ACC)) begin
      proto_err = 1'b1;
    end
    if (!in_first && (state_q == IDLE)) begin
      proto_err = 1'b1;
    end
    if (!win_start && (in_split != split_q)) begin
      proto_err = 1'b1;
    end
  end

  // Next-state: accumulate, close windows into the output register, drain results.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    split_d     = split_q;
    wflags_d    = wflags_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    err_d       = err_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (beat_fire) begin
      if (proto_err) begin
        err_d = 1'b1;
      end
      split_d = mode;
      if (in_last) begin
        out_data_d  = sat_res.value;
        out_sat_d   = flags_new;
        out_valid_d = 1'b1;
        acc_d       = '0;
        wflags_d    = 2'b00;
        state_d     = IDLE;
      end else begin
        acc_d    = sat_res.value;
        wflags_d = flags_new;
        state_d  = ACC;
      end
    end
  end

  // State and datapath registers; reset discards any open window and pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      split_q     <= 1'b0;
      wflags_q    <= 2'b00;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 2'b00;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      split_q     <= split_d;
      wflags_q    <= wflags_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign err       = err_q;

endmodule
